// File: rtl/ps2_scan_ctrl.sv
// PS/2 Set-2 scancode controller: pops receiver FIFO bytes, parses E0/F0 prefixes, emits key events.
// Optional macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the currently held key.
module ps2_scan_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ps2read_data,
    input  logic       ps2read_ready,
    input  logic       ps2read_overflow,
    output logic       ps2read_nextdata,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_down,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic [7:0] press_cnt,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

    state_t state, state_nx;
    logic   pop_wait;
    logic   accept;
    logic   is_e0, is_f0;
    logic   ev_make, ev_break, ev_ext, proto_err;
    logic   held_match, suppress;

    // The FIFO head needs one cycle to advance after a pop, hence pop_wait.
    assign accept           = ps2read_ready && !pop_wait && !rst;
    assign ps2read_nextdata = accept;
    assign is_e0            = (ps2read_data == 8'hE0);
    assign is_f0            = (ps2read_data == 8'hF0);

    always_comb begin
        state_nx  = state;
        ev_make   = 1'b0;
        ev_break  = 1'b0;
        ev_ext    = 1'b0;
        proto_err = 1'b0;
        case (state)
            IDLE: begin
                if (is_e0)      state_nx = EXT;
                else if (is_f0) state_nx = BRK;
                else            ev_make  = 1'b1;
            end
            EXT: begin
                if (is_f0)      state_nx = EXTBRK;
                else if (is_e0) state_nx = EXT;
                else begin
                    ev_make  = 1'b1;
                    ev_ext   = 1'b1;
                    state_nx = IDLE;
                end
            end
            BRK: begin
                state_nx = IDLE;
                if (is_e0 || is_f0) proto_err = 1'b1;
                else                ev_break  = 1'b1;
            end
            EXTBRK: begin
                state_nx = IDLE;
                ev_ext   = 1'b1;
                if (is_e0 || is_f0) proto_err = 1'b1;
                else                ev_break  = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign held_match = key_down && (held_code == ps2read_data) && (held_ext == ev_ext);

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign suppress = ev_make && held_match;
`else
    assign suppress = 1'b0;
`endif

    // Overflow wins over any byte popped in the same cycle, so err and key_valid stay exclusive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pop_wait    <= 1'b0;
            key_valid   <= 1'b0;
            key_code    <= 8'h00;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_down    <= 1'b0;
            held_code   <= 8'h00;
            held_ext    <= 1'b0;
            press_cnt   <= 8'h00;
            err         <= 1'b0;
        end else begin
            pop_wait  <= accept;
            key_valid <= 1'b0;
            err       <= 1'b0;
            if (ps2read_overflow) begin
                err      <= 1'b1;
                state    <= IDLE;
                key_down <= 1'b0;
            end else if (accept) begin
                state <= state_nx;
                if (proto_err)
                    err <= 1'b1;
                if (ev_make && !suppress) begin
                    key_valid   <= 1'b1;
                    key_code    <= ps2read_data;
                    key_ext     <= ev_ext;
                    key_release <= 1'b0;
                    press_cnt   <= press_cnt + 8'd1;
                    key_down    <= 1'b1;
                    held_code   <= ps2read_data;
                    held_ext    <= ev_ext;
                end
                if (ev_break) begin
                    key_valid   <= 1'b1;
                    key_code    <= ps2read_data;
                    key_ext     <= ev_ext;
                    key_release <= 1'b1;
                    if (held_match)
                        key_down <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Self-checking bench for ps2_scan_ctrl: a directed vector table plus hand-written corner sequences.
// Expected values follow PS2_TYPEMATIC_FILTER_EN when the macro is defined for the build.
module tb_ps2_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2read_data;
    logic       ps2read_ready;
    logic       ps2read_overflow;
    logic       ps2read_nextdata;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_down;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] press_cnt;
    logic       err;

`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int b2b_cnt  = 0;
    int both_cnt = 0;
    int vcnt     = 0;
    logic prev_nd = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       v;
        logic       e;
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic       down;
        logic [7:0] hcode;
        logic       hext;
        logic [7:0] cnt;
    } rec_t;

    rec_t vec [16];

    ps2_scan_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .ps2read_data     (ps2read_data),
        .ps2read_ready    (ps2read_ready),
        .ps2read_overflow (ps2read_overflow),
        .ps2read_nextdata (ps2read_nextdata),
        .key_valid        (key_valid),
        .key_code         (key_code),
        .key_ext          (key_ext),
        .key_release      (key_release),
        .key_down         (key_down),
        .held_code        (held_code),
        .held_ext         (held_ext),
        .press_cnt        (press_cnt),
        .err              (err)
    );

    always #5 clk = ~clk;

    // Protocol watchers: back-to-back pops, err/key_valid overlap, key_valid pulse count.
    always @(posedge clk) begin
        if (prev_nd && ps2read_nextdata) b2b_cnt++;
        if (key_valid && err) both_cnt++;
        if (key_valid) vcnt++;
        prev_nd <= ps2read_nextdata;
    end

    function automatic logic [29:0] actualOut();
        return {key_valid, err, key_code, key_ext, key_release, key_down,
                held_code, held_ext, press_cnt};
    endfunction

    task automatic checkOutput(input string name, input logic [29:0] exp);
        checks++;
        if (actualOut() !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (v,e,code,ext,rel,down,hcode,hext,cnt)",
                     name, actualOut(), exp);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Waits (bounded) for the pop strobe; returns at the negedge after the popping edge.
    task automatic waitPop(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (ps2read_nextdata) begin
                @(posedge clk);
                @(negedge clk);
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        bit ok;
        @(negedge clk);
        ps2read_data  = b;
        ps2read_ready = 1'b1;
        waitPop(ok);
        ps2read_ready = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL pop_timeout: byte %h not popped, expected pop within 20 cycles", b);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [29:0] pk(input rec_t r);
        return {r.v, r.e, r.code, r.ext, r.rel, r.down, r.hcode, r.hext, r.cnt};
    endfunction

    initial begin
        bit ok;
        logic [7:0] stream [5];
        logic [7:0] cbase;

        cbase = FILT ? 8'd3 : 8'd5;
        vec[0]  = '{8'h1C, 1, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, 8'd1};
        vec[1]  = '{8'hE0, 0, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, 8'd1};
        vec[2]  = '{8'h75, 1, 0, 8'h75, 1, 0, 1, 8'h75, 1, 8'd2};
        vec[3]  = '{8'hE0, 0, 0, 8'h75, 1, 0, 1, 8'h75, 1, 8'd2};
        vec[4]  = '{8'hF0, 0, 0, 8'h75, 1, 0, 1, 8'h75, 1, 8'd2};
        vec[5]  = '{8'h75, 1, 0, 8'h75, 1, 1, 0, 8'h75, 1, 8'd2};
        vec[6]  = '{8'h1C, 1, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, 8'd3};
        vec[7]  = '{8'h1C, !FILT, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, FILT ? 8'd3 : 8'd4};
        vec[8]  = '{8'h1C, !FILT, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, cbase};
        vec[9]  = '{8'hF0, 0, 0, 8'h1C, 0, 0, 1, 8'h1C, 0, cbase};
        vec[10] = '{8'h1C, 1, 0, 8'h1C, 0, 1, 0, 8'h1C, 0, cbase};
        vec[11] = '{8'hF0, 0, 0, 8'h1C, 0, 1, 0, 8'h1C, 0, cbase};
        vec[12] = '{8'hE0, 0, 1, 8'h1C, 0, 1, 0, 8'h1C, 0, cbase};
        vec[13] = '{8'h29, 1, 0, 8'h29, 0, 0, 1, 8'h29, 0, cbase + 8'd1};
        vec[14] = '{8'hE0, 0, 0, 8'h29, 0, 0, 1, 8'h29, 0, cbase + 8'd1};
        vec[15] = '{8'hF0, 0, 0, 8'h29, 0, 0, 1, 8'h29, 0, cbase + 8'd1};

        rst              = 1'b1;
        ps2read_data     = 8'h00;
        ps2read_ready    = 1'b1;
        ps2read_overflow = 1'b0;
        repeat (3) @(negedge clk);
        checkBit("reset_nextdata", ps2read_nextdata, 1'b0);
        checkOutput("reset_outputs", 30'h0);
        ps2read_ready = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vec[i].data);
            checkOutput($sformatf("vec%0d_%h", i, vec[i].data), pk(vec[i]));
        end
        // Extended break of 29 while non-extended 29 is held: no release of the held key.
        applyStimulus(8'h29);
        checkOutput("ext_break_mismatch", {1'b1, 1'b0, 8'h29, 1'b1, 1'b1, 1'b1, 8'h29, 1'b0, cbase + 8'd1});
        applyStimulus(8'hF0);
        applyStimulus(8'h29);
        checkOutput("break_release_29", {1'b1, 1'b0, 8'h29, 1'b0, 1'b1, 1'b0, 8'h29, 1'b0, cbase + 8'd1});

        // Streaming with ready held high: two events, no prefix events.
        doReset();
        stream = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        @(negedge clk);
        vcnt = 0;
        ps2read_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ps2read_data = stream[i];
            waitPop(ok);
            if (!ok) begin
                checks++;
                failures++;
                $display("[TB] FAIL stream_pop_timeout: byte %0d not popped, expected pop", i);
            end
        end
        ps2read_ready = 1'b0;
        checkOutput("stream_final", {1'b1, 1'b0, 8'h75, 1'b1, 1'b1, 1'b0, 8'h75, 1'b1, 8'd1});
        @(negedge clk);
        checks++;
        if (vcnt != 2) begin
            failures++;
            $display("[TB] FAIL stream_event_count: got %0d expected 2", vcnt);
        end

        // press_cnt wrap over 256 makes of alternating keys, each released.
        doReset();
        for (int i = 0; i < 256; i++) begin
            applyStimulus((i % 2) ? 8'h32 : 8'h1C);
            if (i == 254) checkOutput("cnt_ff", {1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'hFF});
            applyStimulus(8'hF0);
            applyStimulus((i % 2) ? 8'h32 : 8'h1C);
        end
        checkOutput("cnt_wrap", {1'b1, 1'b0, 8'h32, 1'b0, 1'b1, 1'b0, 8'h32, 1'b0, 8'h00});

        // Overflow while a prefix is pending and a byte is being popped.
        doReset();
        applyStimulus(8'h1C);
        applyStimulus(8'hE0);
        @(negedge clk);
        ps2read_data     = 8'h75;
        ps2read_ready    = 1'b1;
        ps2read_overflow = 1'b1;
        #1;
        checkBit("ovf_pop", ps2read_nextdata, 1'b1);
        @(negedge clk);
        ps2read_ready    = 1'b0;
        ps2read_overflow = 1'b0;
        checkOutput("ovf_err", {1'b0, 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 8'd1});
        applyStimulus(8'h1C);
        checkOutput("post_ovf_make", {1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd2});

        // Level overflow pulses err every cycle.
        @(negedge clk);
        ps2read_overflow = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit($sformatf("ovf_level%0d", i), err, 1'b1);
        end
        ps2read_overflow = 1'b0;
        @(negedge clk);
        checkBit("ovf_level_end", err, 1'b0);

        // Reset mid-sequence after F0.
        applyStimulus(8'hF0);
        @(negedge clk);
        rst           = 1'b1;
        ps2read_ready = 1'b1;
        ps2read_data  = 8'h1C;
        #1;
        checkBit("rst_nextdata", ps2read_nextdata, 1'b0);
        @(negedge clk);
        checkOutput("rst_mid_outputs", 30'h0);
        ps2read_ready = 1'b0;
        rst = 1'b0;
        applyStimulus(8'h1C);
        checkOutput("rst_mid_make", {1'b1, 1'b0, 8'h1C, 1'b0, 1'b0, 1'b1, 8'h1C, 1'b0, 8'd1});

        repeat (2) @(negedge clk);
        checks++;
        if (b2b_cnt != 0) begin
            failures++;
            $display("[TB] FAIL nextdata_b2b: got %0d back-to-back pops expected 0", b2b_cnt);
        end
        checks++;
        if (both_cnt != 0) begin
            failures++;
            $display("[TB] FAIL valid_err_overlap: got %0d cycles expected 0", both_cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
